// File: rtl/snake_pkg.sv
// Shared types for the snake body ring: default coordinate widths, coordinate struct, scan FSM states.
package snake_pkg;
  localparam int X_W_DEF = 5;
  localparam int Y_W_DEF = 4;

  typedef struct packed {
    logic [X_W_DEF-1:0] x;
    logic [Y_W_DEF-1:0] y;
  } coord_t;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;
endpackage

// File: rtl/snake_ring_ram.sv
// Body segment storage: one synchronous write port, two combinational read ports.
module snake_ring_ram #(
  parameter int W     = 9,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  output logic [W-1:0]  rdata_a_o,
  input  logic [AW-1:0] raddr_b_i,
  output logic [W-1:0]  rdata_b_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];
endmodule

// File: rtl/snake_body_ring.sv
// Snake body ring buffer with head push / tail retire and a multi-cycle occupancy scan.
// Optional: define SNAKE_SCAN_SKIP_TAIL_EN to exclude the tail segment from the scan.
module snake_body_ring import snake_pkg::*; #(
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_valid,
  output logic                     step_ready,
  input  logic [X_W-1:0]           step_x,
  input  logic [Y_W-1:0]           step_y,
  input  logic                     step_grow,
  output logic [$clog2(MAX_LEN):0] len,
  output logic                     full,
  output logic [X_W-1:0]           head_x,
  output logic [Y_W-1:0]           head_y,
  output logic [X_W-1:0]           tail_x,
  output logic [Y_W-1:0]           tail_y,
  input  logic                     hit_req,
  input  logic [X_W-1:0]           hit_x,
  input  logic [Y_W-1:0]           hit_y,
  output logic                     hit_busy,
  output logic                     hit_done,
  output logic                     hit_found
);
  localparam int PW = $clog2(MAX_LEN);
  localparam int LW = PW + 1;
  localparam int CW = X_W + Y_W;
`ifdef SNAKE_SCAN_SKIP_TAIL_EN
  localparam logic [PW-1:0] START_IDX = PW'(1);
`else
  localparam logic [PW-1:0] START_IDX = '0;
`endif

  scan_state_t   state_q, state_d;
  logic [PW-1:0] head_ptr_q, head_ptr_d, tail_ptr_q, tail_ptr_d, idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic [X_W-1:0] head_x_q, head_x_d, qx_q, qx_d;
  logic [Y_W-1:0] head_y_q, head_y_d, qy_q, qy_d;
  logic          found_q, found_d;
  logic [MAX_LEN-1:0] written_q;

  logic          step_fire, full_c, scan_hit;
  logic [PW-1:0] wr_ptr, scan_ptr;
  logic [CW-1:0] tail_raw, scan_raw, tail_c, scan_c;

  assign full_c    = (len_q == LW'(MAX_LEN));
  assign step_fire = step_valid && (state_q == IDLE);
  assign wr_ptr    = head_ptr_q + 1'b1;
  assign scan_ptr  = tail_ptr_q + idx_q;

  snake_ring_ram #(.W(CW), .DEPTH(MAX_LEN), .AW(PW)) u_ram (
    .clk       (clk),
    .we_i      (step_fire),
    .waddr_i   (wr_ptr),
    .wdata_i   ({step_x, step_y}),
    .raddr_a_i (tail_ptr_q),
    .rdata_a_o (tail_raw),
    .raddr_b_i (scan_ptr),
    .rdata_b_o (scan_raw)
  );

  // Entries not yet written since reset hold the initial body (i,0) implicitly,
  // so the array itself never needs a reset.
  assign tail_c   = written_q[tail_ptr_q] ? tail_raw : {X_W'(tail_ptr_q), {Y_W{1'b0}}};
  assign scan_c   = written_q[scan_ptr]   ? scan_raw : {X_W'(scan_ptr), {Y_W{1'b0}}};
  assign scan_hit = (scan_c == {qx_q, qy_q});

  always_comb begin
    state_d    = state_q;
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    len_d      = len_q;
    head_x_d   = head_x_q;
    head_y_d   = head_y_q;
    idx_d      = idx_q;
    qx_d       = qx_q;
    qy_d       = qy_q;
    found_d    = found_q;

    if (step_fire) begin
      head_ptr_d = wr_ptr;
      head_x_d   = step_x;
      head_y_d   = step_y;
      if (step_grow && !full_c) len_d = len_q + 1'b1;
      else                      tail_ptr_d = tail_ptr_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hit_req) begin
          qx_d    = hit_x;
          qy_d    = hit_y;
          idx_d   = START_IDX;
          found_d = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Start index past the end only happens when skipping the tail of a 1-long body.
        if ({1'b0, idx_q} >= len_q) begin
          state_d = DONE;
        end else if (scan_hit) begin
          found_d = 1'b1;
          state_d = DONE;
        end else if ({1'b0, idx_q} == len_q - 1'b1) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      head_ptr_q <= PW'(INIT_LEN - 1);
      tail_ptr_q <= '0;
      len_q      <= LW'(INIT_LEN);
      head_x_q   <= X_W'(INIT_LEN - 1);
      head_y_q   <= '0;
      idx_q      <= '0;
      qx_q       <= '0;
      qy_q       <= '0;
      found_q    <= 1'b0;
      written_q  <= '0;
    end else begin
      state_q    <= state_d;
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      len_q      <= len_d;
      head_x_q   <= head_x_d;
      head_y_q   <= head_y_d;
      idx_q      <= idx_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      found_q    <= found_d;
      if (step_fire) written_q[wr_ptr] <= 1'b1;
    end
  end

  assign step_ready = (state_q == IDLE);
  assign hit_busy   = (state_q != IDLE);
  assign hit_done   = (state_q == DONE);
  assign hit_found  = found_q;
  assign len        = len_q;
  assign full       = full_c;
  assign head_x     = head_x_q;
  assign head_y     = head_y_q;
  assign {tail_x, tail_y} = tail_c;
endmodule

// File: tb/tb_snake_body_ring.sv
// Randomized self-checking bench for snake_body_ring against a queue-based body model.
module tb_snake_body_ring;
  localparam int X_W = 5, Y_W = 4, MAX_LEN = 32, INIT_LEN = 3;
`ifdef SNAKE_SCAN_SKIP_TAIL_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic step_valid = 0, step_ready, step_grow = 0;
  logic [X_W-1:0] step_x = '0, head_x, tail_x, hit_x = '0;
  logic [Y_W-1:0] step_y = '0, head_y, tail_y, hit_y = '0;
  logic [$clog2(MAX_LEN):0] len;
  logic full, hit_req = 0, hit_busy, hit_done, hit_found;

  snake_body_ring #(.X_W(X_W), .Y_W(Y_W), .MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) dut (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(step_ready),
    .step_x(step_x), .step_y(step_y), .step_grow(step_grow), .len(len), .full(full),
    .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
    .hit_req(hit_req), .hit_x(hit_x), .hit_y(hit_y), .hit_busy(hit_busy),
    .hit_done(hit_done), .hit_found(hit_found)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int bx[$], by[$];  // body model, tail at index 0, head at the end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    bx.delete(); by.delete();
    for (int i = 0; i < INIT_LEN; i++) begin bx.push_back(i); by.push_back(0); end
  endtask

  task automatic model_step(input int x, input int y, input bit g);
    bit keep = g && (bx.size() < MAX_LEN);
    bx.push_back(x); by.push_back(y);
    if (!keep) begin void'(bx.pop_front()); void'(by.pop_front()); end
  endtask

  task automatic check_body(input string tag);
    chk({tag, "_len"},  32'(len),    32'(bx.size()));
    chk({tag, "_full"}, 32'(full),   32'(bx.size() == MAX_LEN));
    chk({tag, "_hx"},   32'(head_x), 32'(bx[bx.size()-1]));
    chk({tag, "_hy"},   32'(head_y), 32'(by[by.size()-1]));
    chk({tag, "_tx"},   32'(tail_x), 32'(bx[0]));
    chk({tag, "_ty"},   32'(tail_y), 32'(by[0]));
  endtask

  task automatic do_reset();
    rst = 1; step_valid = 0; hit_req = 0;
    tick(); tick();
    rst = 0;
    model_reset();
  endtask

  task automatic do_step(input int x, input int y, input bit g, input bit verbose);
    step_valid = 1; step_x = X_W'(x); step_y = Y_W'(y); step_grow = g;
    tick();
    step_valid = 0;
    model_step(x, y, g);
    if (verbose) check_body("step");
  endtask

  // Scan with optional same-cycle step; noise = poke hit_req/step_valid while busy.
  task automatic do_scan(input int qx, input int qy, input bit st, input int sx, input int sy,
                         input bit sg, input bit noise, input string tag);
    int k, lat, m;
    bit exp_found;
    hit_req = 1; hit_x = X_W'(qx); hit_y = Y_W'(qy);
    if (st) begin step_valid = 1; step_x = X_W'(sx); step_y = Y_W'(sy); step_grow = sg; end
    tick();
    hit_req = 0; step_valid = 0;
    if (st) model_step(sx, sy, sg);
    k = -1;
    for (int i = SKIP; i < bx.size(); i++)
      if (k < 0 && bx[i] == qx && by[i] == qy) k = i;
    exp_found = (k >= 0);
    if (exp_found) lat = k + 2 - SKIP;
    else lat = (bx.size() + 1 - SKIP < 2) ? 2 : bx.size() + 1 - SKIP;
    chk({tag, "_busy"}, 32'(hit_busy), 1);
    chk({tag, "_fclr"}, 32'(hit_found), 0);
    m = 0;
    while (!hit_done && m < 200) begin
      if (noise && m == 0) begin
        chk({tag, "_rdy"}, 32'(step_ready), 0);
        hit_req = 1; hit_x = X_W'(bx[0]); hit_y = Y_W'(by[0]);
        step_valid = 1; step_x = 7; step_y = 7; step_grow = 1;
      end else begin
        hit_req = 0; step_valid = 0;
      end
      tick();
      m++;
    end
    hit_req = 0; step_valid = 0;
    chk({tag, "_done"},  32'(hit_done),  1);
    chk({tag, "_found"}, 32'(hit_found), 32'(exp_found));
    chk({tag, "_lat"},   32'(m + 1),     32'(lat));
    tick();
    chk({tag, "_pulse"}, 32'(hit_done),  0);
    chk({tag, "_idle"},  32'(hit_busy),  0);
    chk({tag, "_hold"},  32'(hit_found), 32'(exp_found));
    if (noise) check_body({tag, "_nostep"});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int x, y, r;
    do_reset();
    check_body("rst");
    chk("rst_rdy", 32'(step_ready), 1);
    chk("rst_busy", 32'(hit_busy), 0);
    chk("rst_done", 32'(hit_done), 0);
    chk("rst_found", 32'(hit_found), 0);

    do_scan(1, 0, 0, 0, 0, 0, 0, "q10");
    do_scan(9, 9, 0, 0, 0, 0, 1, "q99");
    do_scan(0, 0, 0, 0, 0, 0, 0, "q00");

    do_step(3, 0, 0, 1); do_step(4, 0, 0, 1); do_step(5, 0, 0, 1);

    do_reset();
    do_scan(3, 0, 1, 3, 0, 0, 0, "same");
    check_body("same");

    do_reset();
    for (int i = 0; i < MAX_LEN - INIT_LEN; i++)
      do_step($urandom_range(0, 31), $urandom_range(0, 15), 1, 0);
    check_body("grow_full");
    do_step($urandom_range(0, 31), $urandom_range(0, 15), 1, 1);
    do_scan(bx[MAX_LEN-1], by[MAX_LEN-1], 0, 0, 0, 0, 0, "fullhead");

    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, bx.size() - 1);
        x = bx[r]; y = by[r];
      end else begin
        x = $urandom_range(0, 31); y = $urandom_range(0, 15);
      end
      case ($urandom_range(0, 3))
        0, 1: do_step($urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 2) == 0, 1);
        2:    do_scan(x, y, 0, 0, 0, 0, $urandom_range(0, 1), "rscan");
        default: do_scan(x, y, 1, $urandom_range(0, 31), $urandom_range(0, 15),
                         $urandom_range(0, 2) == 0, 0, "rboth");
      endcase
      if (it == 60) do_reset();
    end

    hit_req = 1; hit_x = 9; hit_y = 9;
    tick();
    hit_req = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    model_reset();
    chk("midrst_done", 32'(hit_done), 0);
    chk("midrst_busy", 32'(hit_busy), 0);
    chk("midrst_found", 32'(hit_found), 0);
    chk("midrst_rdy", 32'(step_ready), 1);
    check_body("midrst");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("midrst_nodone", 32'(hit_done), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/snake_body_ring.md
Name: snake_body_ring

Overview:
- Parametrised storage engine for the snake's body: a ring buffer of (x,y) segment coordinates, with the head pushed and the tail retired on each game step.
- Adds a multi-cycle occupancy scan that answers "is coordinate (x,y) on the body?". The game FSM uses it for self-collision and food placement.
- Sits between the game-step controller and the collision/food logic inside tt_um_snake_game.

Parameters:
- X_W, 5, x coordinate width
- Y_W, 4, y coordinate width
- MAX_LEN, 32, maximum body length; power of two, >= 2
- INIT_LEN, 3, length after reset; 1 <= INIT_LEN <= MAX_LEN and INIT_LEN <= 2^X_W

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- step_valid  in  1  request to advance the snake one step
- step_ready  out  1  step accepted when valid && ready
- step_x  in  X_W  new head x
- step_y  in  Y_W  new head y
- step_grow  in  1  keep tail this step (food eaten)
- len  out  $clog2(MAX_LEN)+1  current body length
- full  out  1  len == MAX_LEN
- head_x/head_y  out  X_W/Y_W  current head coordinate
- tail_x/tail_y  out  X_W/Y_W  current tail coordinate
- hit_req  in  1  start occupancy scan (accepted only in IDLE)
- hit_x/hit_y  in  X_W/Y_W  query coordinate, latched on accept
- hit_busy  out  1  scan in progress (SCAN or DONE)
- hit_done  out  1  one-cycle pulse: result valid
- hit_found  out  1  scan result; held until the next accepted hit_req

Behaviour:
- Decided interface: one clock clk; reset rst is synchronous and active-high.
- Reset:
  - len=INIT_LEN; segments (0,0)..(INIT_LEN-1,0); tail=(0,0), head=(INIT_LEN-1,0).
  - tail_ptr=0, head_ptr=INIT_LEN-1; all other entries don't-care.
  - State IDLE; hit_busy=0, hit_done=0, hit_found=0; step_ready=1.
- Pointers: $clog2(MAX_LEN) bits wide; wrap-around is natural modulo MAX_LEN.
- Step (accepted cycle):
  - head_ptr+1; write (step_x,step_y) at the new head_ptr.
  - If step_grow && !full: len+1, tail unchanged.
  - Otherwise: tail_ptr+1, len unchanged. A grow while full is silently treated as a plain step; len saturates at MAX_LEN.
  - head/tail/len outputs update the cycle after acceptance.
- step_ready = (state==IDLE). Steps never alter contents during a scan.
- Scan FSM, states IDLE -> SCAN -> DONE -> IDLE:
  - IDLE: hit_req latches the query, sets idx=0 (tail-relative) and clears hit_found. Moves to SCAN.
  - SCAN: each cycle compares the entry at tail_ptr+idx with the query.
  - On match: hit_found=1, go to DONE. Else if idx==len-1: go to DONE. Else idx+1.
  - DONE: hit_done=1 for exactly one cycle, then IDLE.
  - Latency: req sampled at edge t. Miss gives done at t+len+1. Match at index k gives done at t+k+2.
- Simultaneous step and hit_req in IDLE: both accepted. The step commits first and the scan sees post-step contents, including the new len.
- hit_req while busy: ignored; no queueing.
- rst mid-scan: immediate return to the reset state. No hit_done pulse is produced.

Optional Feature:
- SNAKE_SCAN_SKIP_TAIL_EN:
  - Defined: the scan starts at idx=1, because the tail vacates on the next non-grow step. With len==1, SCAN goes straight to DONE with hit_found=0. Latencies shrink by one.
  - Undefined: the tail is included, as described above.

Decomposition:
- snake_pkg holds:
  - default X_W/Y_W localparams
  - typedef coord_t (struct x,y)
  - enum scan_state_t {IDLE,SCAN,DONE}
- Sub-module snake_ring_ram: MAX_LEN x coord_t array with one synchronous write port and two combinational read ports (head/tail, scan index). Reset is not applied to the array contents.

Test Plan:
- Reset: len=3, head=(2,0), tail=(0,0), full=0, step_ready=1, hit_busy=0.
- Three non-grow steps (3,0),(4,0),(5,0): head=(5,0), tail=(3,0), len=3.
- Grow steps from INIT_LEN: 29 grows -> len=32, full=1. One further grow step -> len=32, tail advances one entry; covers pointer wrap past index 31.
- Scans after reset (tail included):
  - query (1,0): hit_found=1, hit_done at t+3.
  - query (9,9): hit_found=0, hit_done at t+4.
  - hit_req during SCAN: ignored.
- Same-cycle step (3,0) and query (3,0): hit_found=1 (post-step contents).
- rst asserted during SCAN: no hit_done pulse; all outputs at reset values next cycle. Under SNAKE_SCAN_SKIP_TAIL_EN, query (0,0) after reset gives hit_found=0.
